// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: helpers shared by the shared-memory crossbar and its banks.
//   bank_bits / row_bits : split of a word address into bank and row fields
//   bank_of / row_of     : low-order interleave decode of a word address
//   rr_pick              : round-robin find-first over a request vector
package gpu_mem_pkg;

  localparam int MAX_CORES  = 64;
  localparam int MAX_ADDR_W = 32;

  function automatic int bank_bits(input int n_banks);
    return $clog2(n_banks);
  endfunction

  function automatic int row_bits(input int addr_w, input int n_banks);
    return addr_w - $clog2(n_banks);
  endfunction

  function automatic int bank_of(input logic [MAX_ADDR_W-1:0] addr, input int n_banks);
    return int'(addr & MAX_ADDR_W'(n_banks - 1));
  endfunction

  function automatic int row_of(input logic [MAX_ADDR_W-1:0] addr, input int n_banks);
    return int'(addr >> $clog2(n_banks));
  endfunction

  // First set bit of req at or after ptr, wrapping at n; -1 when req is empty.
  function automatic int rr_pick(input logic [MAX_CORES-1:0] req, input int ptr, input int n);
    int idx;
    int result;
    result = -1;
    for (int k = 0; k < MAX_CORES; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (result < 0 && req[idx]) result = idx;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// mem_bank: one interleaved SRAM bank with its own round-robin arbiter.
//   clk, reset   : clock, synchronous active-high reset
//   elig_i       : cores eligible at this bank this cycle
//   st_i         : per-core store flag (store wins over load)
//   row_i        : packed per-core row address
//   wdata_i      : packed per-core store data
//   scan_row_i   : scan-port row address
//   grant_o      : one-hot (or zero) grant vector for this cycle
//   rdata_o      : word at the granted core's row, read this cycle
//   scan_data_o  : registered scan-port read data
module mem_bank
  import gpu_mem_pkg::*;
#(
  parameter int N_CORES  = 16,
  parameter int ROW_BITS = 8,
  parameter int DATA_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CORES-1:0]           elig_i,
  input  logic [N_CORES-1:0]           st_i,
  input  logic [N_CORES*ROW_BITS-1:0]  row_i,
  input  logic [N_CORES*DATA_W-1:0]    wdata_i,
  input  logic [ROW_BITS-1:0]          scan_row_i,
  output logic [N_CORES-1:0]           grant_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic [DATA_W-1:0]            scan_data_o
);

  localparam int DEPTH = 1 << ROW_BITS;
  localparam int PTR_W = $clog2(N_CORES);

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [DATA_W-1:0]   scan_q;
  int                  win;
  logic                win_valid, win_st;
  logic [ROW_BITS-1:0] win_row;
  logic [DATA_W-1:0]   win_wdata;

  // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
  always_comb begin
    win       = rr_pick(MAX_CORES'(elig_i), int'(rr_q), N_CORES);
    grant_o   = '0;
    rr_d      = rr_q;
    win_valid = 1'b0;
    win_st    = 1'b0;
    win_row   = '0;
    win_wdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (win == i) begin
        grant_o[i] = 1'b1;
        win_valid  = 1'b1;
        win_st     = st_i[i];
        win_row    = row_i[i*ROW_BITS +: ROW_BITS];
        win_wdata  = wdata_i[i*DATA_W +: DATA_W];
        rr_d       = (i == N_CORES - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  assign rdata_o     = mem_q[win_row];
  assign scan_data_o = scan_q;

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q   <= '0;
      scan_q <= '0;
    end else begin
      rr_q   <= rr_d;
      scan_q <= mem_q[scan_row_i];  // old word on a same-cycle store
    end
  end

  // NOTE: the storage array is deliberately left out of reset so it maps onto plain SRAM.
  always_ff @(posedge clk) begin
    if (!reset && win_valid && win_st) mem_q[win_row] <= win_wdata;
  end

endmodule

// File: rtl/shared_mem_xbar.sv
// shared_mem_xbar: N_CORES cores to N_BANKS low-order-interleaved banks.
//   clk, reset    : clock, synchronous active-high reset
//   mem_req_ld/st : per-core load/store request, held until finish
//   addr_in       : packed per-core word address
//   data_in       : packed per-core store data
//   data_out      : packed per-core load data, valid with finish
//   finish        : one-cycle completion pulse per core
//   scan_addr     : scan-port address; scan_data follows one cycle later
//   conflict_cnt  : saturating count of arbitration losses
//   clear_cnt     : synchronous clear of conflict_cnt
module shared_mem_xbar
  import gpu_mem_pkg::*;
#(
  parameter int N_CORES = 16,
  parameter int N_BANKS = 16,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          mem_req_ld,
  input  logic [N_CORES-1:0]          mem_req_st,
  input  logic [N_CORES*ADDR_W-1:0]   addr_in,
  input  logic [N_CORES*DATA_W-1:0]   data_in,
  output logic [N_CORES*DATA_W-1:0]   data_out,
  output logic [N_CORES-1:0]          finish,
  input  logic [ADDR_W-1:0]           scan_addr,
  output logic [DATA_W-1:0]           scan_data,
  output logic [CNT_W-1:0]            conflict_cnt,
  input  logic                        clear_cnt
);

  localparam int BANK_BITS = bank_bits(N_BANKS);
  localparam int ROW_BITS  = row_bits(ADDR_W, N_BANKS);
  localparam int SUM_W     = $clog2(N_CORES + 1);
  localparam int ACC_W     = CNT_W + SUM_W;

  if (N_BANKS < 2 || (1 << BANK_BITS) != N_BANKS || N_CORES < 2 || N_CORES > MAX_CORES)
  begin : g_bad_params
    $error("shared_mem_xbar: N_BANKS must be a power of two >= 2 and 2 <= N_CORES <= 64");
  end

  logic [N_CORES-1:0]          req, finish_q, grant_all;
  logic [BANK_BITS-1:0]        core_bank [N_CORES];
  logic [N_CORES*ROW_BITS-1:0] core_row;
  logic [N_CORES-1:0]          elig [N_BANKS];
  logic [N_CORES-1:0]          grant [N_BANKS];
  logic [DATA_W-1:0]           bank_rdata [N_BANKS];
  logic [DATA_W-1:0]           bank_scan [N_BANKS];
  logic [N_CORES*DATA_W-1:0]   data_out_q, data_out_d;
  logic [ROW_BITS-1:0]         scan_row;
  logic [BANK_BITS-1:0]        scan_bank_d, scan_bank_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [SUM_W-1:0]            losses;
  logic [ACC_W-1:0]            acc;

  assign req = mem_req_ld | mem_req_st;

  always_comb begin
    core_row = '0;
    for (int i = 0; i < N_CORES; i++) begin
      core_bank[i] = BANK_BITS'(bank_of(MAX_ADDR_W'(addr_in[i*ADDR_W +: ADDR_W]), N_BANKS));
      core_row[i*ROW_BITS +: ROW_BITS] =
        ROW_BITS'(row_of(MAX_ADDR_W'(addr_in[i*ADDR_W +: ADDR_W]), N_BANKS));
    end
    scan_row    = ROW_BITS'(row_of(MAX_ADDR_W'(scan_addr), N_BANKS));
    scan_bank_d = BANK_BITS'(bank_of(MAX_ADDR_W'(scan_addr), N_BANKS));
  end

  // A core still holding its request in its finish cycle is masked so it is not served twice.
  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      elig[b] = '0;
      for (int i = 0; i < N_CORES; i++)
        elig[b][i] = req[i] & ~finish_q[i] & (core_bank[i] == BANK_BITS'(b));
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    mem_bank #(
      .N_CORES  (N_CORES),
      .ROW_BITS (ROW_BITS),
      .DATA_W   (DATA_W)
    ) u_bank (
      .clk         (clk),
      .reset       (reset),
      .elig_i      (elig[b]),
      .st_i        (mem_req_st),
      .row_i       (core_row),
      .wdata_i     (data_in),
      .scan_row_i  (scan_row),
      .grant_o     (grant[b]),
      .rdata_o     (bank_rdata[b]),
      .scan_data_o (bank_scan[b])
    );
  end

  always_comb begin
    grant_all = '0;
    for (int b = 0; b < N_BANKS; b++) grant_all = grant_all | grant[b];

    // Loads capture their bank's read data; stores leave data_out untouched.
    data_out_d = data_out_q;
    for (int i = 0; i < N_CORES; i++)
      if (grant_all[i] && !mem_req_st[i])
        data_out_d[i*DATA_W +: DATA_W] = bank_rdata[core_bank[i]];

    // Each eligible core sits at exactly one bank, so losses = eligible and not granted.
    losses = '0;
    for (int i = 0; i < N_CORES; i++)
      losses = losses + SUM_W'(req[i] & ~finish_q[i] & ~grant_all[i]);

    acc = ACC_W'(cnt_q) + ACC_W'(losses);
    if (clear_cnt)                             cnt_d = '0;
    else if (acc > ACC_W'({CNT_W{1'b1}}))      cnt_d = '1;
    else                                       cnt_d = acc[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      finish_q    <= '0;
      data_out_q  <= '0;
      scan_bank_q <= '0;
      cnt_q       <= '0;
    end else begin
      finish_q    <= grant_all;
      data_out_q  <= data_out_d;
      scan_bank_q <= scan_bank_d;
      cnt_q       <= cnt_d;
    end
  end

  assign finish       = finish_q;
  assign data_out     = data_out_q;
  assign scan_data    = bank_scan[scan_bank_q];
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_shared_mem_xbar.sv
// tb_shared_mem_xbar: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the crossbar.
module tb_shared_mem_xbar;

  localparam int NC    = 16;
  localparam int NB    = 16;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     ld, st;
  logic [NC*AW-1:0]  addr;
  logic [NC*DW-1:0]  wdata;
  logic [NC*DW-1:0]  data_out;
  logic [NC-1:0]     finish;
  logic [AW-1:0]     scan_addr;
  logic [DW-1:0]     scan_data;
  logic [CW-1:0]     conflict_cnt;
  logic              clear_cnt;

  always #5 clk = ~clk;

  shared_mem_xbar #(
    .N_CORES (NC), .N_BANKS (NB), .ADDR_W (AW), .DATA_W (DW), .CNT_W (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req_ld   (ld),
    .mem_req_st   (st),
    .addr_in      (addr),
    .data_in      (wdata),
    .data_out     (data_out),
    .finish       (finish),
    .scan_addr    (scan_addr),
    .scan_data    (scan_data),
    .conflict_cnt (conflict_cnt),
    .clear_cnt    (clear_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: -1 marks an unknown word / value.
  int mem_m [DEPTH];
  int rr_m  [NB];
  bit fin_m [NC];
  int dout_m[NC];
  int lat   [NC];
  int scan_m;
  int cnt_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int core_addr(input int c);
    return int'(addr[c*AW +: AW]);
  endfunction

  task automatic set_req(input int c, input bit l, input bit s, input int a, input int d);
    ld[c] = l;
    st[c] = s;
    addr[c*AW +: AW]  = AW'(a);
    wdata[c*DW +: DW] = DW'(d);
  endtask

  task automatic drop(input int c);
    ld[c] = 1'b0;
    st[c] = 1'b0;
  endtask

  task automatic drop_finished();
    for (int c = 0; c < NC; c++) if (fin_m[c]) drop(c);
  endtask

  // Advance the model by one cycle from the current inputs, clock the DUT, compare.
  task automatic step();
    bit            g[NC];
    int            best, n_elig, losses, a, scan_n;
    logic [NC-1:0] fexp;
    if (reset) begin
      for (int c = 0; c < NC; c++) begin
        fin_m[c] = 1'b0; dout_m[c] = 0; lat[c] = 0;
      end
      for (int b = 0; b < NB; b++) rr_m[b] = 0;
      cnt_m  = 0;
      scan_n = 0;
    end else begin
      scan_n = mem_m[scan_addr];
      for (int c = 0; c < NC; c++) begin
        g[c] = 1'b0;
        if ((ld[c] | st[c]) && !fin_m[c]) lat[c]++;
      end
      losses = 0;
      for (int b = 0; b < NB; b++) begin
        best   = -1;
        n_elig = 0;
        for (int k = 0; k < NC; k++) begin
          int c;
          c = (rr_m[b] + k) % NC;
          if ((ld[c] | st[c]) && !fin_m[c] && (core_addr(c) % NB) == b) begin
            n_elig++;
            if (best < 0) best = c;
          end
        end
        if (best >= 0) begin
          losses += n_elig - 1;
          g[best] = 1'b1;
          rr_m[b] = (best + 1) % NC;
          a = core_addr(best);
          if (st[best]) mem_m[a] = int'(wdata[best*DW +: DW]);
          else          dout_m[best] = mem_m[a];
        end
      end
      if (clear_cnt)                 cnt_m = 0;
      else if (cnt_m + losses > CMAX) cnt_m = CMAX;
      else                           cnt_m = cnt_m + losses;
      for (int c = 0; c < NC; c++) fin_m[c] = g[c];
    end
    scan_m = scan_n;

    @(posedge clk);
    #1;
    cyc++;

    for (int c = 0; c < NC; c++) fexp[c] = fin_m[c];
    check("finish", 64'(finish), 64'(fexp));
    check("conflict_cnt", 64'(conflict_cnt), 64'(cnt_m));
    if (scan_m >= 0) check("scan_data", 64'(scan_data), 64'(scan_m));
    for (int c = 0; c < NC; c++) begin
      if (dout_m[c] >= 0)
        check($sformatf("data_out[%0d]", c), 64'(data_out[c*DW +: DW]), 64'(dout_m[c]));
      if (!reset && finish[c]) begin
        check($sformatf("latency_bound[%0d]", c), 64'(lat[c] >= 1 && lat[c] <= NC), 64'(1));
        lat[c] = 0;
      end
    end
  endtask

  function automatic int rand_addr();
    int bank, row;
    bank = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, NB - 1);
    row  = $urandom_range(0, 7);
    return (row << 4) | bank;
  endfunction

  initial begin
    logic [2:0] exp3;
    int         op;

    reset = 1'b1; ld = '0; st = '0; addr = '0; wdata = '0;
    scan_addr = '0; clear_cnt = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = -1;
    for (int c = 0; c < NC; c++) begin
      dout_m[c] = -1; fin_m[c] = 1'b0; lat[c] = 0;
    end
    for (int b = 0; b < NB; b++) rr_m[b] = 0;
    scan_m = -1;
    cnt_m  = 0;

    // Reset state
    step(); step();
    check("rst_finish",    64'(finish),          64'(0));
    check("rst_dout_lo",   64'(data_out[63:0]),  64'(0));
    check("rst_dout_hi",   64'(data_out[127:64]), 64'(0));
    check("rst_cnt",       64'(conflict_cnt),    64'(0));
    check("rst_scan",      64'(scan_data),       64'(0));
    reset = 1'b0;

    // Single store then load on core 3
    set_req(3, 1'b0, 1'b1, 'h047, 'hA5); step();
    check("t1_st_finish", 64'(finish[3]), 64'(1));
    drop(3); step();
    check("t1_idle", 64'(finish[3]), 64'(0));
    set_req(3, 1'b1, 1'b0, 'h047, 0); step();
    check("t1_ld_finish", 64'(finish[3]), 64'(1));
    check("t1_ld_data",   64'(data_out[3*DW +: DW]), 64'(8'hA5));
    drop(3); step();

    // Three cores on bank 5: round-robin order 0,1,2 and three losses
    clear_cnt = 1'b1; step(); clear_cnt = 1'b0;
    set_req(0, 1'b1, 1'b0, 'h005, 0);
    set_req(1, 1'b1, 1'b0, 'h015, 0);
    set_req(2, 1'b1, 1'b0, 'h025, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      exp3 = 3'b001 << k;
      check($sformatf("t2_order%0d", k), 64'(finish[2:0]), 64'(exp3));
      drop_finished();
    end
    check("t2_cnt", 64'(conflict_cnt), 64'(3));
    step();

    // All cores, distinct banks: all finish together, no conflicts
    for (int c = 0; c < NC; c++) set_req(c, 1'b1, 1'b0, ($urandom_range(0, 7) << 4) | c, 0);
    step();
    check("t3_all_finish", 64'(finish), 64'(16'hFFFF));
    check("t3_cnt",        64'(conflict_cnt), 64'(3));
    for (int c = 0; c < NC; c++) drop(c);
    step();

    // Core 7 holds a load for three cycles: finish 0,1,0,1
    check("t4_f0", 64'(finish[7]), 64'(0));
    set_req(7, 1'b1, 1'b0, 'h047, 0);
    step(); check("t4_f1", 64'(finish[7]), 64'(1));
    check("t4_data", 64'(data_out[7*DW +: DW]), 64'(8'hA5));
    step(); check("t4_f2", 64'(finish[7]), 64'(0));
    step(); check("t4_f3", 64'(finish[7]), 64'(1));
    drop(7); step();

    // Scan and store collide on the same word: old value first, new value next
    set_req(0, 1'b0, 1'b1, 'h010, 'h77); step();
    drop(0); step();
    set_req(0, 1'b0, 1'b1, 'h010, 'h3C);
    scan_addr = AW'('h010);
    step(); check("t5_scan_old", 64'(scan_data), 64'(8'h77));
    drop(0);
    step(); check("t5_scan_new", 64'(scan_data), 64'(8'h3C));

    // Reset during a load grant drops the finish
    set_req(2, 1'b1, 1'b0, 'h047, 0);
    reset = 1'b1; step();
    check("t6_no_finish", 64'(finish), 64'(0));
    check("t6_dout_lo",   64'(data_out[63:0]),   64'(0));
    check("t6_dout_hi",   64'(data_out[127:64]), 64'(0));
    reset = 1'b0; drop(2); step();

    // Eight cores on bank 0 saturate the 4-bit counter, then clear it
    for (int c = 0; c < 8; c++) set_req(c, 1'b1, 1'b0, c << 4, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      drop_finished();
    end
    check("t7_sat", 64'(conflict_cnt), 64'(15));
    clear_cnt = 1'b1; step(); clear_cnt = 1'b0;
    check("t7_clear", 64'(conflict_cnt), 64'(0));

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      clear_cnt = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) scan_addr = AW'(rand_addr());
      for (int c = 0; c < NC; c++) begin
        if (ld[c] | st[c]) begin
          if (fin_m[c] && $urandom_range(0, 3) != 0) drop(c);
        end else if ($urandom_range(0, 1) == 0) begin
          op = $urandom_range(1, 3);
          set_req(c, op[0], op[1], rand_addr(), $urandom_range(0, 255));
        end
      end
      step();
      if (reset) for (int c = 0; c < NC; c++) drop(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
